// File: rtl/gray_seq_ctrl.sv
// Run controller for the 4-bit Gray counter/transition detector: clears the counter,
// enables it for a budgeted number of advances and reports hits, step legality and the final code.
module gray_seq_ctrl #(
  parameter int STEP_W = 8,
  parameter int DCNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [STEP_W-1:0] steps,
  input  logic              stop_on_det,
  input  logic              hold,
  input  logic [3:0]        gray_in,
  input  logic              det_in,
  output logic              cnt_rst,
  output logic              cnt_en,
  output logic              busy,
  output logic              done,
  output logic [DCNT_W-1:0] det_count,
  output logic [3:0]        last_gray,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [STEP_W-1:0] remaining_r;
  logic              stop_lat_r;
  logic              en_d_r;
  logic              done_r;
  logic              err_r;
  logic [3:0]        gray_prev_r;
  logic [3:0]        last_gray_r;
  logic [DCNT_W-1:0] det_count_r;
  logic              start_acc_s;
  logic              stop_hit_s;
  logic              cnt_en_s;
  logic              step_ok_s;

  // A legal Gray advance flips exactly one bit.
  function automatic logic single_bit_change(input logic [3:0] cur, input logic [3:0] prev);
    logic [3:0] diff;
    diff = cur ^ prev;
    return (diff != 4'b0000) && ((diff & (diff - 4'b0001)) == 4'b0000);
  endfunction

  assign start_acc_s = (state_r == IDLE) & start;
  assign stop_hit_s  = stop_lat_r & det_in;
  assign step_ok_s   = single_bit_change(gray_in, gray_prev_r);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; the last enabled advance and a latched-stop hit both end the run
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = CLR;
        else       state_nxt_s = IDLE;
      end
      CLR: begin
        if (remaining_r != {STEP_W{1'b0}}) state_nxt_s = RUN;
        else                               state_nxt_s = FIN;
      end
      RUN: begin
        if (stop_hit_s)                                       state_nxt_s = FIN;
        else if (cnt_en_s && (remaining_r == STEP_W'(1)))     state_nxt_s = FIN;
        else                                                  state_nxt_s = RUN;
      end
      FIN:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Counter control outputs, decoded from the current state
  always_comb begin
    cnt_en_s = (state_r == RUN) & ~hold & ~stop_hit_s;
    cnt_en   = cnt_en_s;
    cnt_rst  = rst | (state_r == CLR);
    busy     = (state_r != IDLE);
  end

  // Step budget and stop mode, latched with an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_r <= {STEP_W{1'b0}};
      stop_lat_r  <= 1'b0;
    end else if (start_acc_s) begin
      remaining_r <= steps;
      stop_lat_r  <= stop_on_det;
    end else if (cnt_en_s) begin
      remaining_r <= remaining_r - STEP_W'(1);
    end
  end

  // Advance monitor and run results; en_d_r marks the cycle showing a fresh counter value
  always_ff @(posedge clk) begin
    if (rst) begin
      en_d_r      <= 1'b0;
      gray_prev_r <= 4'b0000;
      det_count_r <= {DCNT_W{1'b0}};
      err_r       <= 1'b0;
      done_r      <= 1'b0;
      last_gray_r <= 4'b0000;
    end else begin
      en_d_r      <= cnt_en_s;
      gray_prev_r <= gray_in;
      done_r      <= (state_r == FIN);
      if (state_r == FIN) last_gray_r <= gray_in;
      if (start_acc_s) begin
        det_count_r <= {DCNT_W{1'b0}};
        err_r       <= 1'b0;
      end else if (en_d_r) begin
        if (!step_ok_s) err_r <= 1'b1;
        if (det_in && (det_count_r != {DCNT_W{1'b1}})) det_count_r <= det_count_r + DCNT_W'(1);
      end
    end
  end

  assign done      = done_r;
  assign det_count = det_count_r;
  assign last_gray = last_gray_r;
  assign err       = err_r;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Bench for gray_seq_ctrl: a behavioural Gray counter/detector closes the loop and a
// scoreboard of per-run expectations is checked when each run reports done.
module tb_gray_seq_ctrl;
  localparam int STEP_W = 8;
  localparam int DCNT_W = 4;

  logic              clk = 1'b0;
  logic              rst, start, stop_on_det, hold;
  logic [STEP_W-1:0] steps;
  logic [3:0]        gray_in;
  logic              det_in;
  logic              cnt_rst, cnt_en, busy, done, err;
  logic [DCNT_W-1:0] det_count;
  logic [3:0]        last_gray;

  gray_seq_ctrl #(.STEP_W(STEP_W), .DCNT_W(DCNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .steps(steps), .stop_on_det(stop_on_det),
    .hold(hold), .gray_in(gray_in), .det_in(det_in), .cnt_rst(cnt_rst), .cnt_en(cnt_en),
    .busy(busy), .done(done), .det_count(det_count), .last_gray(last_gray), .err(err)
  );

  always #5 clk = ~clk;

  // Counter model; bad_mode makes the second code 0010 instead of 0011
  logic       bad_mode = 1'b0;
  logic [3:0] bin_r, prev_r;
  always_ff @(posedge clk) begin
    if (cnt_rst) bin_r <= 4'd0;
    else if (cnt_en) bin_r <= bin_r + 4'd1;
    if (rst) prev_r <= 4'd0;
    else prev_r <= gray_in;
  end
  always_comb begin
    gray_in = bin_r ^ (bin_r >> 1);
    if (bad_mode && (bin_r == 4'd2)) gray_in = 4'b0010;
    det_in = (gray_in == 4'b1100) && (prev_r == 4'b0100);
  end

  typedef struct {
    logic [3:0] lg;
    logic [3:0] dc;
    logic       e;
    int         en;
    int         lat;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  int         r_en, r_lat, r_busy, r_clr;
  logic [3:0] r_lg, r_dc, r_dc_first;
  logic       r_e, r_busy_done, r_e_first;

  // Expected outcome of a clean run: advances, hits, final code and done latency
  function automatic exp_t model_run(input int n, input logic sod);
    exp_t r;
    int adv, hits;
    logic [3:0] b;
    adv = 0;
    hits = 0;
    for (int k = 1; k <= n; k++) begin
      adv = k;
      if (k % 16 == 8) begin
        hits++;
        if (sod) break;
      end
    end
    b = 4'(adv % 16);
    r.lg = b ^ (b >> 1);
    r.dc = (hits > 15) ? 4'd15 : 4'(hits);
    r.e = 1'b0;
    r.en = adv;
    r.lat = adv + 3 + ((sod && hits > 0 && adv < n) ? 1 : 0);
    return r;
  endfunction

  // Issue one start and observe until done (bounded); results land in r_* variables
  task automatic run_cmd(input int n, input logic sod, input int hold_after,
                         input int hold_len, input logic spam);
    int held, adv;
    held = 0; adv = 0;
    r_en = 0; r_lat = 0; r_busy = 0; r_clr = 0;
    r_lg = 4'hx; r_dc = 4'hx; r_e = 1'bx; r_busy_done = 1'bx;
    @(posedge clk); #1;
    start = 1'b1; steps = STEP_W'(n); stop_on_det = sod; hold = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (adv >= hold_after && held < hold_len) begin
        hold = 1'b1;
        held++;
      end else begin
        hold = 1'b0;
      end
      start = spam & hold;
      #1;
      if (c == 1) begin
        r_e_first = err;
        r_dc_first = det_count;
      end
      if (cnt_rst) r_clr++;
      if (cnt_en) begin
        r_en++;
        adv++;
      end
      if (busy) r_busy++;
      if (done) begin
        r_lat = c; r_lg = last_gray; r_dc = det_count; r_e = err; r_busy_done = busy;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    hold = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; steps = '0; stop_on_det = 1'b0; hold = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0 || cnt_en !== 1'b0) begin n_fail++; $display("FAIL reset_done_en: got %b%b want 00", done, cnt_en); end
    n_checks++; if (det_count !== 4'd0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_dc_err: got %0d/%b want 0/0", det_count, err); end
    n_checks++; if (last_gray !== 4'b0000) begin n_fail++; $display("FAIL reset_last_gray: got %b want 0000", last_gray); end
    n_checks++; if (cnt_rst !== 1'b1) begin n_fail++; $display("FAIL reset_cnt_rst: got %b want 1", cnt_rst); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #2;
    n_checks++; if (cnt_rst !== 1'b0) begin n_fail++; $display("FAIL idle_cnt_rst: got %b want 0", cnt_rst); end
  endtask

  task automatic test_basic;
    exp_t x;
    sb_q.push_back(model_run(5, 1'b0));
    run_cmd(5, 1'b0, 1000, 0, 1'b0);
    x = sb_q.pop_front();
    n_checks++; if (r_en !== x.en) begin n_fail++; $display("FAIL basic_en: got %0d want %0d", r_en, x.en); end
    n_checks++; if (r_lat !== x.lat) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", r_lat, x.lat); end
    n_checks++; if (r_lg !== x.lg) begin n_fail++; $display("FAIL basic_last_gray: got %b want %b", r_lg, x.lg); end
    n_checks++; if (r_dc !== x.dc || r_e !== x.e) begin n_fail++; $display("FAIL basic_dc_err: got %0d/%b want %0d/%b", r_dc, r_e, x.dc, x.e); end
    n_checks++; if (r_clr !== 1) begin n_fail++; $display("FAIL basic_clr_cycles: got %0d want 1", r_clr); end
    n_checks++; if (r_busy_done !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b want 0", r_busy_done); end
    n_checks++; if (r_busy !== x.lat - 1) begin n_fail++; $display("FAIL basic_busy_len: got %0d want %0d", r_busy, x.lat - 1); end
    @(posedge clk); #2;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_stop;
    exp_t x;
    sb_q.push_back(model_run(20, 1'b1));
    run_cmd(20, 1'b1, 1000, 0, 1'b0);
    x = sb_q.pop_front();
    n_checks++; if (r_en !== x.en) begin n_fail++; $display("FAIL stop_en: got %0d want %0d", r_en, x.en); end
    n_checks++; if (r_lat !== x.lat) begin n_fail++; $display("FAIL stop_latency: got %0d want %0d", r_lat, x.lat); end
    n_checks++; if (r_lg !== x.lg) begin n_fail++; $display("FAIL stop_last_gray: got %b want %b", r_lg, x.lg); end
    n_checks++; if (r_dc !== x.dc) begin n_fail++; $display("FAIL stop_det_count: got %0d want %0d", r_dc, x.dc); end
  endtask

  task automatic test_wrap_zero;
    exp_t x;
    sb_q.push_back(model_run(16, 1'b0));
    run_cmd(16, 1'b0, 1000, 0, 1'b0);
    x = sb_q.pop_front();
    n_checks++; if (r_dc_first !== 4'd0) begin n_fail++; $display("FAIL wrap_dc_cleared: got %0d want 0", r_dc_first); end
    n_checks++; if (r_en !== x.en || r_lat !== x.lat) begin n_fail++; $display("FAIL wrap_en_lat: got %0d/%0d want %0d/%0d", r_en, r_lat, x.en, x.lat); end
    n_checks++; if (r_lg !== x.lg) begin n_fail++; $display("FAIL wrap_last_gray: got %b want %b", r_lg, x.lg); end
    n_checks++; if (r_dc !== x.dc || r_e !== x.e) begin n_fail++; $display("FAIL wrap_dc_err: got %0d/%b want %0d/%b", r_dc, r_e, x.dc, x.e); end
    sb_q.push_back(model_run(0, 1'b0));
    run_cmd(0, 1'b0, 1000, 0, 1'b0);
    x = sb_q.pop_front();
    n_checks++; if (r_en !== x.en) begin n_fail++; $display("FAIL zero_en: got %0d want %0d", r_en, x.en); end
    n_checks++; if (r_lat !== x.lat) begin n_fail++; $display("FAIL zero_latency: got %0d want %0d", r_lat, x.lat); end
    n_checks++; if (r_lg !== x.lg || r_clr !== 1) begin n_fail++; $display("FAIL zero_lg_clr: got %b/%0d want %b/1", r_lg, r_clr, x.lg); end
  endtask

  task automatic test_hold;
    exp_t x;
    x = model_run(4, 1'b0);
    x.lat = x.lat + 3;
    sb_q.push_back(x);
    run_cmd(4, 1'b0, 2, 3, 1'b1);
    x = sb_q.pop_front();
    n_checks++; if (r_en !== x.en) begin n_fail++; $display("FAIL hold_en: got %0d want %0d", r_en, x.en); end
    n_checks++; if (r_lat !== x.lat) begin n_fail++; $display("FAIL hold_latency: got %0d want %0d", r_lat, x.lat); end
    n_checks++; if (r_busy !== x.lat - 1) begin n_fail++; $display("FAIL hold_busy_len: got %0d want %0d", r_busy, x.lat - 1); end
    n_checks++; if (r_lg !== x.lg) begin n_fail++; $display("FAIL hold_last_gray: got %b want %b", r_lg, x.lg); end
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_spam_ignored: got busy %b want 0", busy); end
  endtask

  task automatic test_err;
    exp_t x;
    x.lg = 4'b0010; x.dc = 4'd0; x.e = 1'b1; x.en = 2; x.lat = 5;
    sb_q.push_back(x);
    bad_mode = 1'b1;
    run_cmd(2, 1'b0, 1000, 0, 1'b0);
    bad_mode = 1'b0;
    x = sb_q.pop_front();
    n_checks++; if (r_e !== x.e) begin n_fail++; $display("FAIL err_set: got %b want %b", r_e, x.e); end
    n_checks++; if (r_lg !== x.lg || r_en !== x.en) begin n_fail++; $display("FAIL err_lg_en: got %b/%0d want %b/%0d", r_lg, r_en, x.lg, x.en); end
    repeat (3) @(posedge clk);
    #2;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
    sb_q.push_back(model_run(1, 1'b0));
    run_cmd(1, 1'b0, 1000, 0, 1'b0);
    x = sb_q.pop_front();
    n_checks++; if (r_e_first !== 1'b0) begin n_fail++; $display("FAIL err_cleared_on_start: got %b want 0", r_e_first); end
    n_checks++; if (r_e !== x.e || r_lg !== x.lg) begin n_fail++; $display("FAIL err_clean_run: got %b/%b want %b/%b", r_e, r_lg, x.e, x.lg); end
  endtask

  task automatic test_abort;
    int seen, dones, busies;
    seen = 0; dones = 0; busies = 0;
    @(posedge clk); #1;
    start = 1'b1; steps = STEP_W'(10); stop_on_det = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 50 && seen < 3; c++) begin
      #1;
      if (cnt_en) seen++;
      @(posedge clk); #1;
    end
    n_checks++; if (seen !== 3) begin n_fail++; $display("FAIL abort_advances: got %0d want 3", seen); end
    rst = 1'b1;
    #1;
    n_checks++; if (cnt_rst !== 1'b1) begin n_fail++; $display("FAIL abort_cnt_rst: got %b want 1", cnt_rst); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || cnt_en !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy %b en %b want 0 0", busy, cnt_en); end
    n_checks++; if (det_count !== 4'd0) begin n_fail++; $display("FAIL abort_det_count: got %0d want 0", det_count); end
    for (int c = 0; c < 12; c++) begin
      if (done) dones++;
      if (busy) busies++;
      @(posedge clk); #2;
    end
    n_checks++; if (dones !== 0 || busies !== 0) begin n_fail++; $display("FAIL abort_no_done: got done %0d busy %0d want 0 0", dones, busies); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stop();
    test_wrap_zero();
    test_hold();
    test_err();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
